// File: rtl/ascon_pkg.sv
// ascon_pkg: core stream widths, bdi/bdo type codes and arbiter state encoding.
// Shared by the arbiter, its round-robin picker and any client of the core.
package ascon_pkg;
    localparam int CCW  = 32;
    localparam int CCSW = 32;
    localparam logic [3:0] D_NULL  = 4'd0;
    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_PTCT  = 4'd3;
    localparam logic [3:0] D_TAG   = 4'd4;
    localparam logic [3:0] D_HASH  = 4'd5;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    // An operation opens with a key word, a nonce word, or (hash only) an AD word.
    function automatic logic op_start(input logic key_valid, input logic bdi_valid,
                                      input logic [3:0] bdi_type, input logic hash);
        return key_valid | (bdi_valid & ((bdi_type == D_NONCE) | ((bdi_type == D_AD) & hash)));
    endfunction
endpackage

// File: rtl/ascon_arbiter_rr_pick.sv
// rr_pick: combinational one-hot round-robin selector.
// The first requester at or after ptr_i (wrapping) wins; zero when nobody requests.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);
    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ascon_arbiter.sv
// ascon_arbiter: lends one shared ascon_core to one of NUM_REQ requesters per whole operation.
// Round-robin fair; define ASCON_ARB_STATS_EN to add per-requester completed-op counters (op_cnt).
module ascon_arbiter
    import ascon_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ*CCSW-1:0] r_key,
    input  logic [NUM_REQ-1:0]      r_key_valid,
    output logic [NUM_REQ-1:0]      r_key_ready,
    input  logic [NUM_REQ*CCW-1:0]  r_bdi,
    input  logic [NUM_REQ-1:0]      r_bdi_valid,
    output logic [NUM_REQ-1:0]      r_bdi_ready,
    input  logic [NUM_REQ*4-1:0]    r_bdi_type,
    input  logic [NUM_REQ-1:0]      r_bdi_eot,
    input  logic [NUM_REQ-1:0]      r_bdi_eoi,
    input  logic [NUM_REQ-1:0]      r_decrypt,
    input  logic [NUM_REQ-1:0]      r_hash,
    output logic [NUM_REQ*CCW-1:0]  r_bdo,
    output logic [NUM_REQ-1:0]      r_bdo_valid,
    input  logic [NUM_REQ-1:0]      r_bdo_ready,
    output logic [NUM_REQ*4-1:0]    r_bdo_type,
    output logic [NUM_REQ-1:0]      r_bdo_eot,
    output logic [NUM_REQ-1:0]      r_auth,
    output logic [NUM_REQ-1:0]      r_auth_valid,
    input  logic [NUM_REQ-1:0]      r_auth_ready,
    output logic [CCSW-1:0]         c_key,
    output logic                    c_key_valid,
    input  logic                    c_key_ready,
    output logic [CCW-1:0]          c_bdi,
    output logic                    c_bdi_valid,
    input  logic                    c_bdi_ready,
    output logic [3:0]              c_bdi_type,
    output logic                    c_bdi_eot,
    output logic                    c_bdi_eoi,
    output logic                    c_decrypt,
    output logic                    c_hash,
    input  logic [CCW-1:0]          c_bdo,
    input  logic                    c_bdo_valid,
    output logic                    c_bdo_ready,
    input  logic [3:0]              c_bdo_type,
    input  logic                    c_bdo_eot,
    input  logic                    c_auth,
    input  logic                    c_auth_valid,
    output logic                    c_auth_ready,
    output logic [NUM_REQ-1:0]      grant
`ifdef ASCON_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]   op_cnt
`endif
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    arb_state_t state_q, state_d;
    logic [PW-1:0] owner_q, owner_d, ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req, pick, sel;
    logic busy, release_op;
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req[i] = op_start(r_key_valid[i], r_bdi_valid[i], r_bdi_type[i*4 +: 4], r_hash[i]);
    end
    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (.req_i(req), .ptr_i(ptr_q), .gnt_o(pick));
    assign busy = state_q == ARB_BUSY;
    always_comb begin
        sel = '0;
        if (busy) sel[owner_q] = 1'b1;
    end
    assign grant = sel;
    always_comb begin
        c_key        = '0;
        c_key_valid  = 1'b0;
        c_bdi        = '0;
        c_bdi_valid  = 1'b0;
        c_bdi_type   = D_NULL;
        c_bdi_eot    = 1'b0;
        c_bdi_eoi    = 1'b0;
        c_decrypt    = 1'b0;
        c_hash       = 1'b0;
        c_bdo_ready  = 1'b0;
        c_auth_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) begin
                c_key        = r_key[i*CCSW +: CCSW];
                c_key_valid  = r_key_valid[i];
                c_bdi        = r_bdi[i*CCW +: CCW];
                c_bdi_valid  = r_bdi_valid[i];
                c_bdi_type   = r_bdi_type[i*4 +: 4];
                c_bdi_eot    = r_bdi_eot[i];
                c_bdi_eoi    = r_bdi_eoi[i];
                c_decrypt    = r_decrypt[i];
                c_hash       = r_hash[i];
                c_bdo_ready  = r_bdo_ready[i];
                c_auth_ready = r_auth_ready[i];
            end
        end
    end
    // Core outputs reach the owner only; c_auth_valid lingers in the core after verify, so it is gated too.
    always_comb begin
        r_bdo = '0;
        r_bdo_type = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            r_key_ready[i]          = sel[i] & c_key_ready;
            r_bdi_ready[i]          = sel[i] & c_bdi_ready;
            r_bdo[i*CCW +: CCW]     = sel[i] ? c_bdo : '0;
            r_bdo_valid[i]          = sel[i] & c_bdo_valid;
            r_bdo_type[i*4 +: 4]    = sel[i] ? c_bdo_type : D_NULL;
            r_bdo_eot[i]            = sel[i] & c_bdo_eot;
            r_auth[i]               = sel[i] & c_auth;
            r_auth_valid[i]         = sel[i] & c_auth_valid;
        end
    end
    assign release_op = busy & ((c_bdo_valid & c_bdo_ready & c_bdo_eot &
                                 ((c_bdo_type == D_TAG) | (c_bdo_type == D_HASH))) |
                                (c_auth_valid & c_auth_ready));
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (!busy && |req) begin
            state_d = ARB_BUSY;
            for (int i = 0; i < NUM_REQ; i++)
                if (pick[i]) owner_d = PW'(i);
        end else if (release_op) begin
            state_d = ARB_IDLE;
            ptr_d   = owner_q == PW'(NUM_REQ - 1) ? '0 : owner_q + PW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end
`ifdef ASCON_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] cnt_q;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst)
                cnt_q[i*16 +: 16] <= '0;
            else if (release_op && sel[i] && cnt_q[i*16 +: 16] != 16'hFFFF)
                cnt_q[i*16 +: 16] <= cnt_q[i*16 +: 16] + 16'd1;
        end
    end
    assign op_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_ascon_arbiter.sv
// tb_ascon_arbiter: table-driven grant sequence, hand-written corner cases and random traffic
// checked every cycle against an owner/pointer reference model (stats checked with ASCON_ARB_STATS_EN).
module tb_ascon_arbiter;
    import ascon_pkg::*;
    localparam int N = 2;
    logic clk = 1'b0, rst;
    always #5 clk = ~clk;
    logic [N*CCSW-1:0] r_key;
    logic [N*CCW-1:0]  r_bdi, r_bdo;
    logic [N*4-1:0]    r_bdi_type, r_bdo_type;
    logic [N-1:0] r_key_valid, r_key_ready, r_bdi_valid, r_bdi_ready, r_bdi_eot, r_bdi_eoi;
    logic [N-1:0] r_decrypt, r_hash, r_bdo_valid, r_bdo_ready, r_bdo_eot;
    logic [N-1:0] r_auth, r_auth_valid, r_auth_ready, grant;
    logic [CCSW-1:0] c_key;
    logic [CCW-1:0]  c_bdi, c_bdo;
    logic [3:0]      c_bdi_type, c_bdo_type;
    logic c_key_valid, c_key_ready, c_bdi_valid, c_bdi_ready, c_bdi_eot, c_bdi_eoi, c_decrypt, c_hash;
    logic c_bdo_valid, c_bdo_ready, c_bdo_eot, c_auth, c_auth_valid, c_auth_ready;
`ifdef ASCON_ARB_STATS_EN
    logic [N*16-1:0] op_cnt;
`endif
    ascon_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .r_key(r_key), .r_key_valid(r_key_valid), .r_key_ready(r_key_ready),
        .r_bdi(r_bdi), .r_bdi_valid(r_bdi_valid), .r_bdi_ready(r_bdi_ready),
        .r_bdi_type(r_bdi_type), .r_bdi_eot(r_bdi_eot), .r_bdi_eoi(r_bdi_eoi),
        .r_decrypt(r_decrypt), .r_hash(r_hash),
        .r_bdo(r_bdo), .r_bdo_valid(r_bdo_valid), .r_bdo_ready(r_bdo_ready),
        .r_bdo_type(r_bdo_type), .r_bdo_eot(r_bdo_eot),
        .r_auth(r_auth), .r_auth_valid(r_auth_valid), .r_auth_ready(r_auth_ready),
        .c_key(c_key), .c_key_valid(c_key_valid), .c_key_ready(c_key_ready),
        .c_bdi(c_bdi), .c_bdi_valid(c_bdi_valid), .c_bdi_ready(c_bdi_ready),
        .c_bdi_type(c_bdi_type), .c_bdi_eot(c_bdi_eot), .c_bdi_eoi(c_bdi_eoi),
        .c_decrypt(c_decrypt), .c_hash(c_hash),
        .c_bdo(c_bdo), .c_bdo_valid(c_bdo_valid), .c_bdo_ready(c_bdo_ready),
        .c_bdo_type(c_bdo_type), .c_bdo_eot(c_bdo_eot),
        .c_auth(c_auth), .c_auth_valid(c_auth_valid), .c_auth_ready(c_auth_ready),
        .grant(grant)
`ifdef ASCON_ARB_STATS_EN
        , .op_cnt(op_cnt)
`endif
    );
    int n_chk = 0, n_fail = 0;
    int own = -1, ptr = 0;
    int cnt [N];
    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask
    function automatic logic is_req(input int i);
        return r_key_valid[i] | (r_bdi_valid[i] & (r_bdi_type[i*4 +: 4] == D_NONCE |
               (r_bdi_type[i*4 +: 4] == D_AD & r_hash[i])));
    endfunction
    task automatic check_all();
        logic [N-1:0] g;
        logic [75:0] ce;
        g = '0;
        ce = '0;
        if (own >= 0) begin
            g[own] = 1'b1;
            ce = {r_key[own*CCSW +: CCSW], r_key_valid[own], r_bdi[own*CCW +: CCW], r_bdi_valid[own],
                  r_bdi_type[own*4 +: 4], r_bdi_eot[own], r_bdi_eoi[own], r_decrypt[own], r_hash[own],
                  r_bdo_ready[own], r_auth_ready[own]};
        end
        chk("grant", grant, g);
        chk("core_side", {c_key, c_key_valid, c_bdi, c_bdi_valid, c_bdi_type, c_bdi_eot, c_bdi_eoi,
                          c_decrypt, c_hash, c_bdo_ready, c_auth_ready}, ce);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("req%0d_side", i),
                {r_key_ready[i], r_bdi_ready[i], r_bdo[i*CCW +: CCW], r_bdo_valid[i], r_bdo_type[i*4 +: 4],
                 r_bdo_eot[i], r_auth[i], r_auth_valid[i]},
                (i == own) ? {c_key_ready, c_bdi_ready, c_bdo, c_bdo_valid, c_bdo_type, c_bdo_eot,
                              c_auth, c_auth_valid} : 42'd0);
`ifdef ASCON_ARB_STATS_EN
            chk($sformatf("op_cnt%0d", i), op_cnt[i*16 +: 16], 16'(cnt[i]));
`endif
        end
    endtask
    task automatic model_step();
        int pick;
        pick = -1;
        if (rst) begin
            own = -1;
            ptr = 0;
            for (int i = 0; i < N; i++) cnt[i] = 0;
        end else if (own < 0) begin
            for (int k = N - 1; k >= 0; k--) if (is_req((ptr + k) % N)) pick = (ptr + k) % N;
            own = pick;
        end else if ((c_bdo_valid & r_bdo_ready[own] & c_bdo_eot & (c_bdo_type == D_TAG | c_bdo_type == D_HASH)) |
                     (c_auth_valid & r_auth_ready[own])) begin
            if (cnt[own] < 65535) cnt[own]++;
            ptr = (own + 1) % N;
            own = -1;
        end
    endtask
    task automatic cyc();
        #1 check_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic clr();
        rst = 0; r_key = '0; r_key_valid = '0; r_bdi = '0; r_bdi_valid = '0; r_bdi_type = '0;
        r_bdi_eot = '0; r_bdi_eoi = '0; r_decrypt = '0; r_hash = '0; r_bdo_ready = '0; r_auth_ready = '0;
        c_key_ready = 0; c_bdi_ready = 0; c_bdo = '0; c_bdo_valid = 0; c_bdo_type = D_NULL;
        c_bdo_eot = 0; c_auth = 0; c_auth_valid = 0;
    endtask
    task automatic op(input int i);
        r_key_valid[i] = 1'b1;
        cyc();
        r_key_valid[i] = 1'b0;
        c_bdo_valid = 1; c_bdo_eot = 1; c_bdo_type = D_TAG; r_bdo_ready[i] = 1'b1;
        cyc();
        c_bdo_valid = 0; c_bdo_eot = 0; r_bdo_ready = '0;
        cyc();
    endtask
    typedef struct {
        logic [N-1:0] kv;
        logic         te;
        logic [3:0]   bt;
        logic [N-1:0] g;
    } vec_t;
    vec_t tbl [18];
    initial begin
        tbl[0]  = '{2'b11, 1'b0, D_NULL, 2'b00};
        tbl[1]  = '{2'b11, 1'b0, D_NULL, 2'b01};
        tbl[2]  = '{2'b11, 1'b1, D_TAG,  2'b01};
        tbl[3]  = '{2'b11, 1'b0, D_NULL, 2'b00};
        tbl[4]  = '{2'b11, 1'b0, D_NULL, 2'b10};
        tbl[5]  = '{2'b11, 1'b1, D_TAG,  2'b10};
        tbl[6]  = '{2'b01, 1'b0, D_NULL, 2'b00};
        tbl[7]  = '{2'b01, 1'b0, D_NULL, 2'b01};
        tbl[8]  = '{2'b00, 1'b0, D_NULL, 2'b01};
        tbl[9]  = '{2'b00, 1'b1, D_PTCT, 2'b01};
        tbl[10] = '{2'b00, 1'b1, D_HASH, 2'b01};
        tbl[11] = '{2'b10, 1'b0, D_NULL, 2'b00};
        tbl[12] = '{2'b10, 1'b0, D_NULL, 2'b10};
        tbl[13] = '{2'b01, 1'b1, D_TAG,  2'b10};
        tbl[14] = '{2'b10, 1'b0, D_NULL, 2'b00};
        tbl[15] = '{2'b00, 1'b1, D_TAG,  2'b10};
        tbl[16] = '{2'b00, 1'b0, D_NULL, 2'b00};
        tbl[17] = '{2'b00, 1'b0, D_NULL, 2'b00};
        for (int i = 0; i < N; i++) cnt[i] = 0;
        clr();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        cyc();
        rst = 0;
        op(0); op(0); op(0); op(1);
`ifdef ASCON_ARB_STATS_EN
        #1 chk("stats_3_1", op_cnt, {16'd1, 16'd3});
`endif
        for (int i = 0; i < 18; i++) begin
            r_key_valid = tbl[i].kv;
            c_bdo_valid = tbl[i].te; c_bdo_eot = tbl[i].te; c_bdo_type = tbl[i].bt; r_bdo_ready = '1;
            #1 chk($sformatf("tbl%0d_grant", i), grant, tbl[i].g);
            cyc();
        end
        clr();
        r_bdi_valid = 2'b11; r_bdi_type = {D_NONCE, D_AD}; r_hash = 2'b01;
        cyc();
        #1 chk("hash_grant", grant, 2'b01);
        r_bdi_valid[0] = 1'b0;
        for (int w = 0; w < 8; w++) begin
            c_bdo = 32'hA5A5_0000 + 32'(w); c_bdo_valid = 1; c_bdo_type = D_HASH; c_bdo_eot = (w == 7);
            if (w == 3) begin
                r_bdo_ready[0] = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1 chk("hash_stall_data", {r_bdo[CCW-1:0], r_bdo_valid, c_bdo_ready}, {32'hA5A5_0003, 2'b01, 1'b0});
                    cyc();
                end
            end
            r_bdo_ready[0] = 1'b1;
            #1 chk("hash_word", {r_bdo[CCW-1:0], r_bdo_eot[0], grant}, {32'hA5A5_0000 + 32'(w), w == 7, 2'b01});
            cyc();
        end
        c_bdo_valid = 0; c_bdo_eot = 0; r_bdo_ready = '0;
        #1 chk("hash_release_idle", grant, 2'b00);
        cyc();
        #1 chk("req1_after_2cyc", grant, 2'b10);
        clr();
        r_decrypt = 2'b10; c_auth_valid = 1; c_auth = 0; r_auth_ready = 2'b10;
        #1 chk("auth_bad", {r_auth_valid, r_auth, c_decrypt}, {2'b10, 2'b00, 1'b1});
        cyc();
        for (int s = 0; s < 3; s++) begin
            #1 chk("auth_masked", r_auth_valid, 2'b00);
            cyc();
        end
        clr();
        r_key_valid = 2'b01;
        cyc();
        r_key_valid = 2'b10; r_bdi_valid = 2'b01; r_bdi_type = {D_NULL, D_PTCT}; c_bdi_ready = 1; c_key_ready = 1;
        #1 chk("ptct_owner", {grant, r_bdi_ready}, {2'b01, 2'b01});
        rst = 1;
        cyc();
        rst = 0;
        #1 chk("rst_abort", {grant, r_bdi_ready, r_key_ready}, 6'd0);
        cyc();
        #1 chk("rst_next_op", {grant, r_key_ready}, {2'b10, 2'b10});
        r_key_valid = '0; r_bdi_valid = '0; c_bdo_valid = 1; c_bdo_eot = 1; c_bdo_type = D_TAG; r_bdo_ready = 2'b10;
        cyc();
        clr();
        #1 chk("rst_next_done", grant, 2'b00);
        cyc();
        for (int t = 0; t < 3000; t++) begin
            rst = $urandom_range(0, 199) == 0;
            r_key = {$urandom, $urandom}; r_bdi = {$urandom, $urandom};
            r_key_valid = N'($urandom) & N'($urandom); r_bdi_valid = N'($urandom);
            for (int i = 0; i < N; i++) r_bdi_type[i*4 +: 4] = D_NONCE + 4'($urandom_range(0, 3));
            r_bdi_eot = N'($urandom); r_bdi_eoi = N'($urandom); r_decrypt = N'($urandom); r_hash = N'($urandom);
            r_bdo_ready = N'($urandom); r_auth_ready = N'($urandom);
            c_key_ready = 1'($urandom); c_bdi_ready = 1'($urandom); c_bdo = $urandom;
            c_bdo_valid = 1'($urandom); c_bdo_type = 4'($urandom_range(0, 5));
            c_bdo_eot = $urandom_range(0, 3) == 0; c_auth = 1'($urandom); c_auth_valid = $urandom_range(0, 7) == 0;
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
